sigmoid_scheduler: RTL and testbench

- Shares one sigmoid activation unit between N neuron requesters.
- The unit covers forward (arg→res) and, when training, backward (err→fbk).
- Selects a requester round-robin, drives the unit's `en` from that requester's training bit, and routes all four handshake channels to and from it until its transaction completes.
- Sits between the neuron array and the single sigmoid instance.

---
 rtl/sigmoid_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/sigmoid_scheduler.sv | 149 ++++++++++++++
 tb/tb_sigmoid_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// Shared definitions for the sigmoid scheduler: transaction states and default
// channel widths of the single sigmoid activation unit.
package sigmoid_pkg;

    localparam int ARG_W = 16;
    localparam int RES_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG  = 3'd1,
        RES  = 3'd2,
        ERR  = 3'd3,
        FBK  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: returns the first set request found
// searching upward from last+1, wrapping at N.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        // k runs 1..N so the previous winner is considered last
        for (int k = 1; k <= N; k++) begin
            if (!any && req[(int'(last) + k) % N]) begin
                any = 1'b1;
                idx = IDX_W'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Round-robin scheduler sharing one sigmoid unit between N neuron requesters;
// routes arg/res (and err/fbk when training) to the granted requester.
module sigmoid_scheduler #(
    parameter int N     = 4,
    parameter int ARG_W = sigmoid_pkg::ARG_W,
    parameter int RES_W = sigmoid_pkg::RES_W,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_trn,
    input  logic [N-1:0]       req_arg_stb,
    input  logic [N*ARG_W-1:0] req_arg_dat,
    output logic [N-1:0]       req_arg_rdy,
    output logic [N-1:0]       req_res_stb,
    output logic [RES_W-1:0]   req_res_dat,
    input  logic [N-1:0]       req_res_rdy,
    input  logic [N-1:0]       req_err_stb,
    input  logic [N*ARG_W-1:0] req_err_dat,
    output logic [N-1:0]       req_err_rdy,
    output logic [N-1:0]       req_fbk_stb,
    output logic [ARG_W-1:0]   req_fbk_dat,
    input  logic [N-1:0]       req_fbk_rdy,
    output logic               act_en,
    output logic               act_arg_stb,
    output logic [ARG_W-1:0]   act_arg_dat,
    input  logic               act_arg_rdy,
    input  logic               act_res_stb,
    input  logic [RES_W-1:0]   act_res_dat,
    output logic               act_res_rdy,
    output logic               act_err_stb,
    output logic [ARG_W-1:0]   act_err_dat,
    input  logic               act_err_rdy,
    input  logic               act_fbk_stb,
    input  logic [ARG_W-1:0]   act_fbk_dat,
    output logic               act_fbk_rdy,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx
);

    import sigmoid_pkg::*;

    state_t           state_reg;
    logic [IDX_W-1:0] gnt_idx_reg;
    logic [IDX_W-1:0] last_reg;
    logic             trn_reg;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic [ARG_W-1:0] arg_slice [N];
    logic [ARG_W-1:0] err_slice [N];
    logic [N-1:0]     sel;

    logic in_arg, in_res, in_err, in_fbk;

    rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req  (req_arg_stb),
        .last (last_reg),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign in_arg = (state_reg == ARG);
    assign in_res = (state_reg == RES);
    assign in_err = (state_reg == ERR);
    assign in_fbk = (state_reg == FBK);

    // Per-requester unpacking and return-path gating; only the granted
    // requester ever sees a ready or strobe.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign arg_slice[gi]   = req_arg_dat[gi*ARG_W +: ARG_W];
            assign err_slice[gi]   = req_err_dat[gi*ARG_W +: ARG_W];
            assign sel[gi]         = (gnt_idx_reg == IDX_W'(gi));
            assign req_arg_rdy[gi] = in_arg & sel[gi] & act_arg_rdy;
            assign req_res_stb[gi] = in_res & sel[gi] & act_res_stb;
            assign req_err_rdy[gi] = in_err & sel[gi] & act_err_rdy;
            assign req_fbk_stb[gi] = in_fbk & sel[gi] & act_fbk_stb;
        end
    endgenerate

    assign act_arg_stb = in_arg & req_arg_stb[gnt_idx_reg];
    assign act_arg_dat = arg_slice[gnt_idx_reg];
    assign act_res_rdy = in_res & req_res_rdy[gnt_idx_reg];
    assign act_err_stb = in_err & req_err_stb[gnt_idx_reg];
    assign act_err_dat = err_slice[gnt_idx_reg];
    assign act_fbk_rdy = in_fbk & req_fbk_rdy[gnt_idx_reg];

    assign req_res_dat = act_res_dat;
    assign req_fbk_dat = act_fbk_dat;

    assign gnt_vld = (state_reg != IDLE);
    assign gnt_idx = gnt_idx_reg;
    // trn is latched at grant, so later req_trn changes cannot disturb the unit
    assign act_en  = trn_reg & (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_idx_reg <= '0;
            last_reg    <= IDX_W'(N - 1);
            trn_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx_reg <= pick_idx;
                        trn_reg     <= req_trn[pick_idx];
                        state_reg   <= ARG;
                    end
                end
                ARG: begin
                    if (act_arg_stb && act_arg_rdy) begin
                        state_reg <= RES;
                    end
                end
                RES: begin
                    if (act_res_stb && act_res_rdy) begin
                        if (trn_reg) begin
                            state_reg <= ERR;
                        end else begin
                            state_reg <= IDLE;
                            last_reg  <= gnt_idx_reg;
                        end
                    end
                end
                ERR: begin
                    if (act_err_stb && act_err_rdy) begin
                        state_reg <= FBK;
                    end
                end
                FBK: begin
                    if (act_fbk_stb && act_fbk_rdy) begin
                        state_reg <= IDLE;
                        last_reg  <= gnt_idx_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_scheduler.sv
// Self-checking bench: the bench plays both the requesters and the sigmoid
// unit, predicting grants from a simple round-robin search model.
module tb_sigmoid_scheduler;

    localparam int N     = 4;
    localparam int ARG_W = 16;
    localparam int RES_W = 8;
    localparam int IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_trn;
    logic [N-1:0]       req_arg_stb;
    logic [N*ARG_W-1:0] req_arg_dat;
    logic [N-1:0]       req_arg_rdy;
    logic [N-1:0]       req_res_stb;
    logic [RES_W-1:0]   req_res_dat;
    logic [N-1:0]       req_res_rdy;
    logic [N-1:0]       req_err_stb;
    logic [N*ARG_W-1:0] req_err_dat;
    logic [N-1:0]       req_err_rdy;
    logic [N-1:0]       req_fbk_stb;
    logic [ARG_W-1:0]   req_fbk_dat;
    logic [N-1:0]       req_fbk_rdy;
    logic               act_en;
    logic               act_arg_stb;
    logic [ARG_W-1:0]   act_arg_dat;
    logic               act_arg_rdy;
    logic               act_res_stb;
    logic [RES_W-1:0]   act_res_dat;
    logic               act_res_rdy;
    logic               act_err_stb;
    logic [ARG_W-1:0]   act_err_dat;
    logic               act_err_rdy;
    logic               act_fbk_stb;
    logic [ARG_W-1:0]   act_fbk_dat;
    logic               act_fbk_rdy;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;

    int checks   = 0;
    int failures = 0;
    int last_m;

    always #5 clk = ~clk;

    sigmoid_scheduler #(
        .N(N), .ARG_W(ARG_W), .RES_W(RES_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_trn(req_trn),
        .req_arg_stb(req_arg_stb), .req_arg_dat(req_arg_dat), .req_arg_rdy(req_arg_rdy),
        .req_res_stb(req_res_stb), .req_res_dat(req_res_dat), .req_res_rdy(req_res_rdy),
        .req_err_stb(req_err_stb), .req_err_dat(req_err_dat), .req_err_rdy(req_err_rdy),
        .req_fbk_stb(req_fbk_stb), .req_fbk_dat(req_fbk_dat), .req_fbk_rdy(req_fbk_rdy),
        .act_en(act_en),
        .act_arg_stb(act_arg_stb), .act_arg_dat(act_arg_dat), .act_arg_rdy(act_arg_rdy),
        .act_res_stb(act_res_stb), .act_res_dat(act_res_dat), .act_res_rdy(act_res_rdy),
        .act_err_stb(act_err_stb), .act_err_dat(act_err_dat), .act_err_rdy(act_err_rdy),
        .act_fbk_stb(act_fbk_stb), .act_fbk_dat(act_fbk_dat), .act_fbk_rdy(act_fbk_rdy),
        .gnt_vld(gnt_vld), .gnt_idx(gnt_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requesting index strictly after 'last', wrapping around
    function automatic int pick_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_req"}, 32'({req_arg_rdy, req_res_stb, req_err_rdy, req_fbk_stb}), 0);
        chk({tag, "_act"}, 32'({act_arg_stb, act_res_rdy, act_err_stb, act_fbk_rdy, act_en, gnt_vld}), 0);
    endtask

    // One complete transaction, entered during an IDLE cycle with requests set
    task automatic txn(input int dly, input logic [RES_W-1:0] res_val,
                       input logic [ARG_W-1:0] err_val, input logic [ARG_W-1:0] fbk_val,
                       input bit rst_in_fbk);
        int p;
        logic exp_trn;
        logic [N-1:0] oh;
        p = pick_model(req_arg_stb, last_m);
        exp_trn = req_trn[p];
        oh = '0;
        oh[p] = 1'b1;
        chk("idle_gnt_vld", 32'(gnt_vld), 0);
        chk("idle_arg_stb", 32'(act_arg_stb), 0);

        step();
        req_trn = ~req_trn;
        act_res_stb = 1'b1;
        act_fbk_stb = 1'b1;
        req_res_rdy = '1;
        req_fbk_rdy = '1;
        #1;
        chk("arg_gnt_vld", 32'(gnt_vld), 1);
        chk("arg_gnt_idx", 32'(gnt_idx), 32'(p));
        chk("arg_act_en", 32'(act_en), 32'(exp_trn));
        chk("arg_act_stb", 32'(act_arg_stb), 1);
        chk("arg_act_dat", 32'(act_arg_dat), 32'(req_arg_dat[p*ARG_W +: ARG_W]));
        chk("arg_spur_res", 32'({req_res_stb, act_res_rdy}), 0);
        chk("arg_spur_fbk", 32'({req_fbk_stb, act_fbk_rdy}), 0);
        repeat (dly) begin
            chk("arg_wait_rdy", 32'(req_arg_rdy), 0);
            step();
        end
        act_arg_rdy = 1'b1;
        #1;
        chk("arg_ack_rdy", 32'(req_arg_rdy), 32'(oh));

        step();
        req_arg_stb[p] = 1'b0;
        act_arg_rdy = 1'b0;
        act_fbk_stb = 1'b0;
        req_fbk_rdy = '0;
        act_res_stb = 1'b1;
        act_res_dat = res_val;
        req_res_rdy = ~oh;
        #1;
        chk("res_arg_stb", 32'(act_arg_stb), 0);
        chk("res_stb", 32'(req_res_stb), 32'(oh));
        chk("res_dat", 32'(req_res_dat), 32'(res_val));
        repeat (dly) begin
            chk("res_wait_rdy", 32'(act_res_rdy), 0);
            chk("res_wait_idx", 32'({gnt_vld, gnt_idx}), 32'({1'b1, 2'(p)}));
            step();
        end
        req_res_rdy[p] = 1'b1;
        #1;
        chk("res_ack_rdy", 32'(act_res_rdy), 1);

        step();
        act_res_stb = 1'b0;
        req_res_rdy = '0;
        if (exp_trn) begin
            req_err_stb = N'($urandom);
            req_err_stb[p] = 1'b1;
            req_err_dat = {N{ARG_W'($urandom)}};
            req_err_dat[p*ARG_W +: ARG_W] = err_val;
            act_res_stb = 1'b1;
            #1;
            chk("err_gnt_vld", 32'(gnt_vld), 1);
            chk("err_act_en", 32'(act_en), 1);
            chk("err_act_stb", 32'(act_err_stb), 1);
            chk("err_act_dat", 32'(act_err_dat), 32'(err_val));
            chk("err_spur_res", 32'(req_res_stb), 0);
            repeat (dly) begin
                chk("err_wait_rdy", 32'(req_err_rdy), 0);
                step();
            end
            act_err_rdy = 1'b1;
            #1;
            chk("err_ack_rdy", 32'(req_err_rdy), 32'(oh));

            step();
            req_err_stb = '0;
            act_err_rdy = 1'b0;
            act_res_stb = 1'b0;
            act_fbk_stb = 1'b1;
            act_fbk_dat = fbk_val;
            req_fbk_rdy = ~oh;
            #1;
            chk("fbk_err_stb", 32'(act_err_stb), 0);
            chk("fbk_stb", 32'(req_fbk_stb), 32'(oh));
            chk("fbk_dat", 32'(req_fbk_dat), 32'(fbk_val));
            chk("fbk_act_en", 32'(act_en), 1);
            if (rst_in_fbk) begin
                #1;
                rst_n = 1'b0;
                #1;
                check_idle("rst_fbk");
                last_m = N - 1;
                act_fbk_stb = 1'b0;
                req_fbk_rdy = '0;
                return;
            end
            repeat (dly) begin
                chk("fbk_wait_rdy", 32'(act_fbk_rdy), 0);
                step();
            end
            req_fbk_rdy[p] = 1'b1;
            #1;
            chk("fbk_ack_rdy", 32'(act_fbk_rdy), 1);
            step();
            act_fbk_stb = 1'b0;
            req_fbk_rdy = '0;
        end
        #1;
        last_m = p;
        chk("end_gnt_vld", 32'(gnt_vld), 0);
        chk("end_act_en", 32'(act_en), 0);
        $display("txn req=%0d trn=%0d res=%0h err=%0h fbk=%0h", p, exp_trn, res_val, err_val, fbk_val);
    endtask

    initial begin
        logic [N-1:0] new_req;
        rst_n = 1'b0;
        req_trn = '0; req_arg_stb = '0; req_arg_dat = '0; req_res_rdy = '0;
        req_err_stb = '0; req_err_dat = '0; req_fbk_rdy = '0;
        act_arg_rdy = 1'b0; act_res_stb = 1'b0; act_res_dat = '0;
        act_err_rdy = 1'b0; act_fbk_stb = 1'b0; act_fbk_dat = '0;
        last_m = N - 1;

        repeat (2) @(posedge clk);
        #2;
        check_idle("reset");
        chk("reset_gnt_idx", 32'(gnt_idx), 0);
        rst_n = 1'b1;
        step();
        #1;
        check_idle("post_reset");

        // Single non-training request from requester 2
        req_arg_dat[2*ARG_W +: ARG_W] = 16'h0123;
        req_trn = 4'b0000;
        req_arg_stb = 4'b0100;
        #1;
        txn(2, 8'h5a, 16'h0, 16'h0, 1'b0);

        // Backpressure on result; requester 0 must wait behind requester 3
        req_arg_dat[3*ARG_W +: ARG_W] = 16'h7777;
        req_arg_dat[0*ARG_W +: ARG_W] = 16'h1111;
        req_trn = 4'b0000;
        req_arg_stb = 4'b1001;
        #1;
        txn(5, 8'hc3, 16'h0, 16'h0, 1'b0);
        chk("bp_waiter_last", 32'(last_m), 3);
        req_trn = 4'b0000;
        #1;
        txn(1, 8'h01, 16'h0, 16'h0, 1'b0);
        chk("bp_waiter_next", 32'(last_m), 0);

        // Training transaction from requester 1
        req_arg_dat[1*ARG_W +: ARG_W] = 16'h2222;
        req_trn = 4'b0010;
        req_arg_stb = 4'b0010;
        #1;
        txn(1, 8'h80, 16'h0400, 16'h0040, 1'b0);

        // Requester 3 granted with trn=1; req_trn flips during the transaction
        req_trn = 4'b1000;
        req_arg_stb = 4'b1000;
        #1;
        txn(0, 8'h44, 16'h0abc, 16'h0def, 1'b0);

        // Asynchronous reset during FBK
        req_trn = 4'b0100;
        req_arg_stb = 4'b0100;
        #1;
        txn(1, 8'h99, 16'h1234, 16'h4321, 1'b1);
        req_arg_stb = '0;
        req_trn = '0;
        step();
        chk("in_reset_gnt_idx", 32'(gnt_idx), 0);
        #1;
        rst_n = 1'b1;
        #1;
        check_idle("after_rst");

        // All four requesting continuously: 0,1,2,3,0
        req_arg_stb = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            req_trn = '0;
            #1;
            txn(1, RES_W'($urandom), 16'h0, 16'h0, 1'b0);
            chk("rr_order", 32'(last_m), 32'(k % N));
            req_arg_stb[last_m] = 1'b1;
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            new_req = N'($urandom);
            if ((req_arg_stb | new_req) == '0) new_req[$urandom_range(0, N-1)] = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (new_req[j] && !req_arg_stb[j]) req_arg_dat[j*ARG_W +: ARG_W] = ARG_W'($urandom);
            end
            req_arg_stb = req_arg_stb | new_req;
            req_trn = N'($urandom);
            #1;
            txn($urandom_range(0, 3), RES_W'($urandom), ARG_W'($urandom), ARG_W'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
